// File: rtl/mem_access_unit_pkg.sv
// Shared types, FSM encodings and lane helpers for the RV32I data-memory access unit.
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t IDLE = 2'd0;
    localparam mem_state_t BUSY = 2'd1;
    localparam mem_state_t RESP = 2'd2;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    // Any size encoding other than byte/half is handled as a full word.
    function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            SZ_B:    return 4'b0001 << addr;
            SZ_H:    return 4'b0011 << {addr[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_replicate(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3[1:0])
            SZ_B:    return {4{data[7:0]}};
            SZ_H:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [1:0] natural_offset(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            SZ_B:    return addr;
            SZ_H:    return {addr[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            SZ_B:    return 1'b0;
            SZ_H:    return addr[0];
            default: return addr != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the access unit (master) and data memory (slave).
interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load formatting: selects the addressed byte/half lane and sign- or zero-extends it.
module load_align #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    import riscv_mem_pkg::*;

    logic [15:0] lane;
    logic        sext;

    always_comb begin
        lane = 16'(rdata >> {addr_lo, 3'b000});
        sext = ~funct3[2];
        case (funct3[1:0])
            SZ_B:    data = {{(XLEN-8){sext & lane[7]}}, lane[7:0]};
            SZ_H:    data = {{(XLEN-16){sext & lane[15]}}, lane[15:0]};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: IDLE/BUSY/RESP handshake FSM, stall generation, load formatting.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned accesses instead of truncating them.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWriteM,
    input  logic [1:0]          ResultSrcM,
    input  logic                MemWriteM,
    input  logic [2:0]          Funct3M,
    input  logic [XLEN-1:0]     ALUResultM,
    input  logic [XLEN-1:0]     WriteDataM,
    output logic                RegWriteOutM,
    output logic [1:0]          ResultSrcOutM,
    output logic [XLEN-1:0]     ReadDataM,
    output logic                StallM,
    output logic                MisalignM,
    output logic                dmem_timeout,
    mem_access_unit_if.master   dmem
);
    localparam int CNT_W = $clog2(MAX_WAIT + 2);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             req_p1, we_p1;
    logic [XLEN-1:0]  addr_p1, wdata_p1, load_fmt;
    logic [3:0]       be_p1;
    logic [1:0]       off_p1, off_nat;
    logic [2:0]       f3_p1;
    logic             access, trap, issue;

    assign access  = MemWriteM | (ResultSrcM == RESULT_SRC_LOAD);
    assign off_nat = natural_offset(Funct3M, ALUResultM[1:0]);
`ifdef MISALIGN_TRAP_EN
    assign trap = (state == IDLE) & access & is_misaligned(Funct3M, ALUResultM[1:0]);
`else
    assign trap = 1'b0;
`endif
    assign issue = (state == IDLE) & access & ~trap;

    assign StallM        = issue | (state == BUSY);
    assign MisalignM     = trap;
    assign RegWriteOutM  = RegWriteM & ~trap;
    assign ResultSrcOutM = ResultSrcM;
    // Counter equals the BUSY cycle index and parks one past the limit, so the pulse fires once.
    assign dmem_timeout  = (state == BUSY) & ~dmem.dmem_ready & (cnt == WAIT_LIM);

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata   (dmem.dmem_rdata),
        .addr_lo (off_p1),
        .funct3  (f3_p1),
        .data    (load_fmt)
    );

    // p1: request registers held stable for the whole BUSY phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_p1    <= 1'b0;
            we_p1     <= 1'b0;
            addr_p1   <= '0;
            be_p1     <= '0;
            wdata_p1  <= '0;
            off_p1    <= '0;
            f3_p1     <= '0;
            ReadDataM <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (issue) begin
                        req_p1   <= 1'b1;
                        we_p1    <= MemWriteM;
                        addr_p1  <= {ALUResultM[XLEN-1:2], 2'b00};
                        be_p1    <= byte_enable(Funct3M, off_nat);
                        wdata_p1 <= store_replicate(Funct3M, WriteDataM);
                        off_p1   <= off_nat;
                        f3_p1    <= Funct3M;
                        cnt      <= CNT_W'(1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ready) begin
                        req_p1 <= 1'b0;
                        if (!we_p1) ReadDataM <= load_fmt;
                        state  <= RESP;
                    end else if (cnt <= WAIT_LIM) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = req_p1;
    assign dmem.dmem_we    = we_p1;
    assign dmem.dmem_addr  = addr_p1;
    assign dmem.dmem_be    = be_p1;
    assign dmem.dmem_wdata = wdata_p1;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (honours MISALIGN_TRAP_EN if defined).
module tb_mem_access_unit;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        RegWriteOutM, StallM, MisalignM, dmem_timeout;
    logic [1:0]  ResultSrcOutM;
    logic [31:0] ReadDataM;

    int total  = 0;
    int passed = 0;

    mem_access_unit_if #(.XLEN(32)) dmem ();

    mem_access_unit #(.XLEN(32), .MAX_WAIT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWriteM     (RegWriteM),
        .ResultSrcM    (ResultSrcM),
        .MemWriteM     (MemWriteM),
        .Funct3M       (Funct3M),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .RegWriteOutM  (RegWriteOutM),
        .ResultSrcOutM (ResultSrcOutM),
        .ReadDataM     (ReadDataM),
        .StallM        (StallM),
        .MisalignM     (MisalignM),
        .dmem_timeout  (dmem_timeout),
        .dmem          (dmem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic set_add();
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b00;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        ALUResultM = 32'h0000_0042;
        WriteDataM = 32'h0;
        dmem.dmem_ready = 1'b0;
    endtask

    // Called at a negedge; ready is raised for BUSY cycle number d (1 = first BUSY cycle).
    task automatic run_access(input logic st, input logic rw, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int d, output int stalls, output int tcnt, output int tpos,
                              output logic [31:0] c_addr, output logic [31:0] c_wdata,
                              output logic [3:0] c_be, output logic c_req, output logic c_we,
                              output logic done, output logic resp_req);
        RegWriteM  = rw;
        ResultSrcM = st ? 2'b00 : RESULT_SRC_LOAD;
        MemWriteM  = st;
        Funct3M    = f3;
        ALUResultM = a;
        WriteDataM = wd;
        dmem.dmem_rdata = rd;
        dmem.dmem_ready = 1'b0;
        stalls = 0; tcnt = 0; tpos = 0; done = 1'b0; resp_req = 1'b1;
        c_addr = '0; c_wdata = '0; c_be = '0; c_req = 1'b0; c_we = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            #1;
            if (i == 1) begin
                c_req = dmem.dmem_req; c_we = dmem.dmem_we; c_addr = dmem.dmem_addr;
                c_be = dmem.dmem_be; c_wdata = dmem.dmem_wdata;
            end
            if (dmem_timeout) begin tcnt++; tpos = i; end
            if (StallM) stalls++;
            else begin done = 1'b1; resp_req = dmem.dmem_req; end
            @(negedge clk);
            dmem.dmem_ready = (i + 1 == d);
        end
        set_add();
    endtask

    int          stalls, tcnt, tpos;
    logic [31:0] c_addr, c_wdata, prev;
    logic [3:0]  c_be;
    logic        c_req, c_we, done, resp_req;

    initial begin
        reset = 1'b0;
        set_add();
        dmem.dmem_rdata = 32'h0;
        #12;
        chk("rst_req", 32'(dmem.dmem_req), 32'h0);
        chk("rst_we", 32'(dmem.dmem_we), 32'h0);
        chk("rst_addr", dmem.dmem_addr, 32'h0);
        chk("rst_be", 32'(dmem.dmem_be), 32'h0);
        chk("rst_wdata", dmem.dmem_wdata, 32'h0);
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_stall", 32'(StallM), 32'h0);
        chk("rst_misalign", 32'(MisalignM), 32'h0);
        chk("rst_timeout", 32'(dmem_timeout), 32'h0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        // Non-access instruction passes straight through
        #1;
        chk("add_stall", 32'(StallM), 32'h0);
        chk("add_regwrite", 32'(RegWriteOutM), 32'h1);
        chk("add_resultsrc", 32'(ResultSrcOutM), 32'h0);
        @(negedge clk); #1;
        chk("add_req", 32'(dmem.dmem_req), 32'h0);
        @(negedge clk);

        // LW 0x100, ready on first BUSY cycle
        run_access(1'b0, 1'b1, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 1,
                   stalls, tcnt, tpos, c_addr, c_wdata, c_be, c_req, c_we, done, resp_req);
        chk("lw_done", 32'(done), 32'h1);
        chk("lw_req", 32'(c_req), 32'h1);
        chk("lw_we", 32'(c_we), 32'h0);
        chk("lw_addr", c_addr, 32'h100);
        chk("lw_be", 32'(c_be), 32'hF);
        chk("lw_stalls", 32'(stalls), 32'd2);
        chk("lw_resp_req", 32'(resp_req), 32'h0);
        chk("lw_data", ReadDataM, 32'hDEAD_BEEF);

        // LB / LBU 0x103
        run_access(1'b0, 1'b1, F3_B, 32'h103, 32'h0, 32'h80FF_FF7F, 1,
                   stalls, tcnt, tpos, c_addr, c_wdata, c_be, c_req, c_we, done, resp_req);
        chk("lb_be", 32'(c_be), 32'h8);
        chk("lb_addr", c_addr, 32'h100);
        chk("lb_data", ReadDataM, 32'hFFFF_FF80);
        run_access(1'b0, 1'b1, F3_BU, 32'h103, 32'h0, 32'h80FF_FF7F, 1,
                   stalls, tcnt, tpos, c_addr, c_wdata, c_be, c_req, c_we, done, resp_req);
        chk("lbu_data", ReadDataM, 32'h0000_0080);

        // LH / LHU 0x102
        run_access(1'b0, 1'b1, F3_H, 32'h102, 32'h0, 32'h8001_1234, 1,
                   stalls, tcnt, tpos, c_addr, c_wdata, c_be, c_req, c_we, done, resp_req);
        chk("lh_be", 32'(c_be), 32'hC);
        chk("lh_data", ReadDataM, 32'hFFFF_8001);
        run_access(1'b0, 1'b1, F3_HU, 32'h102, 32'h0, 32'h8001_1234, 1,
                   stalls, tcnt, tpos, c_addr, c_wdata, c_be, c_req, c_we, done, resp_req);
        chk("lhu_data", ReadDataM, 32'h0000_8001);

        // SH 0x202; store must leave ReadDataM untouched
        prev = ReadDataM;
        RegWriteM = 1'b0;
        #1 chk("sh_regwrite", 32'(RegWriteOutM), 32'h0);
        run_access(1'b1, 1'b0, F3_H, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 1,
                   stalls, tcnt, tpos, c_addr, c_wdata, c_be, c_req, c_we, done, resp_req);
        chk("sh_we", 32'(c_we), 32'h1);
        chk("sh_addr", c_addr, 32'h200);
        chk("sh_be", 32'(c_be), 32'hC);
        chk("sh_wdata", c_wdata, 32'hABCD_ABCD);
        chk("sh_stalls", 32'(stalls), 32'd2);
        chk("sh_rdata_kept", ReadDataM, prev);

        // SB 0x101
        run_access(1'b1, 1'b0, F3_B, 32'h101, 32'h0000_00A5, 32'h0, 1,
                   stalls, tcnt, tpos, c_addr, c_wdata, c_be, c_req, c_we, done, resp_req);
        chk("sb_be", 32'(c_be), 32'h2);
        chk("sb_wdata", c_wdata, 32'hA5A5_A5A5);

        // LW with ready on the 20th BUSY cycle
        run_access(1'b0, 1'b1, F3_W, 32'h300, 32'h0, 32'hCAFE_F00D, 20,
                   stalls, tcnt, tpos, c_addr, c_wdata, c_be, c_req, c_we, done, resp_req);
        chk("slow_done", 32'(done), 32'h1);
        chk("slow_stalls", 32'(stalls), 32'd21);
        chk("slow_tcnt", 32'(tcnt), 32'd1);
        chk("slow_tpos", 32'(tpos), 32'd15);
        chk("slow_data", ReadDataM, 32'hCAFE_F00D);

        // dmem_ready while idle is ignored
        prev = ReadDataM;
        dmem.dmem_ready = 1'b1;
        dmem.dmem_rdata = 32'h1111_1111;
        #1 chk("ign_stall", 32'(StallM), 32'h0);
        @(negedge clk); dmem.dmem_ready = 1'b0; #1;
        chk("ign_req", 32'(dmem.dmem_req), 32'h0);
        chk("ign_rdata", ReadDataM, prev);
        @(negedge clk);

        // Misaligned LW 0x101
`ifdef MISALIGN_TRAP_EN
        RegWriteM = 1'b1; ResultSrcM = RESULT_SRC_LOAD; MemWriteM = 1'b0;
        Funct3M = F3_W; ALUResultM = 32'h101;
        #1;
        chk("mis_flag", 32'(MisalignM), 32'h1);
        chk("mis_regwrite", 32'(RegWriteOutM), 32'h0);
        chk("mis_stall", 32'(StallM), 32'h0);
        @(negedge clk); #1;
        chk("mis_req", 32'(dmem.dmem_req), 32'h0);
        set_add();
        @(negedge clk);
`else
        run_access(1'b0, 1'b1, F3_W, 32'h101, 32'h0, 32'h0102_0304, 1,
                   stalls, tcnt, tpos, c_addr, c_wdata, c_be, c_req, c_we, done, resp_req);
        chk("mis_addr", c_addr, 32'h100);
        chk("mis_be", 32'(c_be), 32'hF);
        chk("mis_data", ReadDataM, 32'h0102_0304);
        #1 chk("mis_flag", 32'(MisalignM), 32'h0);
        @(negedge clk);
`endif

        // Reset asserted while BUSY
        RegWriteM = 1'b1; ResultSrcM = RESULT_SRC_LOAD; MemWriteM = 1'b0;
        Funct3M = F3_W; ALUResultM = 32'h400; dmem.dmem_rdata = 32'h7777_7777;
        @(negedge clk); #1;
        chk("rstb_req_before", 32'(dmem.dmem_req), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("rstb_req", 32'(dmem.dmem_req), 32'h0);
        chk("rstb_rdata", ReadDataM, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        set_add();
        #1;
        chk("rstb_add_stall", 32'(StallM), 32'h0);
        @(negedge clk); #1;
        chk("rstb_add_req", 32'(dmem.dmem_req), 32'h0);
        chk("rstb_add_stall2", 32'(StallM), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
